// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator that turns pipeline load/store requests
// into word-aligned, byte-enabled data-memory transactions. An access that
// crosses a 4-byte boundary is split into two transactions. Load lanes are
// merged and sign/zero extended, and the result comes back with a one-cycle
// response pulse.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_type,
  input  logic              req_u,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state;

  // Request fields latched at accept time
  logic        we_q;
  logic        u_q;
  logic [1:0]  type_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [2:0]  hi_be_q;
  logic        split_q;
  logic [31:0] lo;

  // Values derived from the incoming request
  logic [6:0]  accept_mask;
  logic        accept_split;
  logic [31:0] accept_wdata;

  // Second-transaction write data
  logic [5:0]  hi_shift;
  logic [31:0] hi_wdata;

  // Load merge and extension
  logic [55:0] merged;
  logic [31:0] load_raw;
  logic [31:0] load_result;

  // Byte-lane mask of the access, shifted to its offset; bits 6:4 spill into the next word
  function automatic logic [6:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [6:0] base;
    case (size)
      2'b00:   base = 7'b0000001;
      2'b01:   base = 7'b0000011;
      default: base = 7'b0001111;
    endcase
    return base << off;
  endfunction

  // True when the access runs past the end of its first word
  function automatic logic access_split(input logic [1:0] size, input logic [1:0] off);
    logic [2:0] n;
    case (size)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return ({1'b0, off} + n) > 3'd4;
  endfunction

  // Sign or zero extension of the right-justified load value
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic u);
    logic [31:0] res;
    case (size)
      2'b00:   res = u ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   res = u ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Lane mask, split flag and lane-shifted write data for the request being offered
  always_comb begin
    accept_mask  = lane_mask(req_type, req_addr[1:0]);
    accept_split = access_split(req_type, req_addr[1:0]);
    accept_wdata = req_wdata << {req_addr[1:0], 3'b000};
  end

  // Upper store bytes are moved down to the low lanes of the following word
  always_comb begin
    hi_shift = {3'd4 - {1'b0, off_q}, 3'b000};
    hi_wdata = wdata_q >> hi_shift;
  end

  // Merge the final ack's read data with the captured low word and extract the access;
  // only 24 bits of the upper word can ever land in the result, since offset >= 1 when split
  always_comb begin
    merged = (state == ACC1) ? {mem_rdata[23:0], lo} : {24'h0, mem_rdata};
    case (off_q)
      2'd0:    load_raw = merged[31:0];
      2'd1:    load_raw = merged[39:8];
      2'd2:    load_raw = merged[47:16];
      default: load_raw = merged[55:24];
    endcase
    load_result = extend(load_raw, type_q, u_q);
  end

  // Main FSM: accepts a request, issues one or two memory transactions, then pulses the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      we_q      <= 1'b0;
      u_q       <= 1'b0;
      type_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      hi_be_q   <= '0;
      split_q   <= 1'b0;
      lo        <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            u_q       <= req_u;
            type_q    <= req_type;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata;
            hi_be_q   <= accept_mask[6:4];
            split_q   <= accept_split;
            lo        <= '0;
            req_ready <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= accept_mask[3:0];
            mem_wdata <= accept_wdata;
            state     <= ACC0;
          end
        end
        ACC0: begin
          if (mem_ack) begin
            if (!we_q) begin
              lo <= mem_rdata;
            end
            if (split_q) begin
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_be    <= {1'b0, hi_be_q};
              mem_wdata <= hi_wdata;
              state     <= ACC1;
            end else begin
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_be    <= '0;
              mem_wdata <= '0;
              rsp_valid <= 1'b1;
              rsp_rdata <= we_q ? 32'h0 : load_result;
              state     <= RESP;
            end
          end
        end
        ACC1: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? 32'h0 : load_result;
            state     <= RESP;
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven bench for load_store_unit with a byte-level
// memory model, a transaction scoreboard and a response scoreboard.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_type;
  logic              req_u;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_u(req_u), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  typ;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] exp_rdata;
    int          exp_lat;
    string       name;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          acc_cyc;
    string       name;
  } rsp_t;

  vec_t        vecs[$];
  txn_t        exp_txn[$];
  rsp_t        exp_rsp[$];
  logic [7:0]  mem_bytes [256];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_rsp = 1'b0;
  logic [68:0] prev_bus = '0;

  // Edge counter used to measure accept-to-response latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [71:0] actual,
                             input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic setWord(input logic [7:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem_bytes[8'(a + 8'(i))] = v[8*i +: 8];
  endtask

  // Memory responder plus bus and response monitors, all sampled on the falling edge
  always @(negedge clk) begin : monitor
    txn_t        e;
    rsp_t        r;
    logic [31:0] lane_mask;
    logic [31:0] word;
    if (rst) begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      wcnt      = 0;
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
      prev_rsp  = 1'b0;
    end else begin
      if (prev_rsp) checkOutput("rsp_pulse", 72'(rsp_valid), 72'(0));
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: actual rsp_valid=1 rdata=%0h, required no response",
                   rsp_rdata);
        end else begin
          r = exp_rsp.pop_front();
          checkOutput({r.name, "_rdata"}, 72'(rsp_rdata), 72'(r.rdata));
          checkOutput({r.name, "_latency"}, 72'(cyc + 1 - r.acc_cyc), 72'(r.lat));
        end
      end
      prev_rsp = rsp_valid;

      if (mem_req) begin
        checkOutput("be_nonzero", 72'(mem_be == 4'b0000), 72'(0));
        checkOutput("addr_align", 72'(mem_addr[1:0]), 72'(0));
        checkOutput("ready_busy", 72'(req_ready), 72'(0));
        if (prev_req && !prev_ack)
          checkOutput("req_stable", 72'({mem_we, mem_addr, mem_be, mem_wdata}), 72'(prev_bus));
      end

      if (!mem_req) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        wcnt      = 0;
      end else if (wcnt >= wait_cfg) begin
        for (int i = 0; i < 4; i++) word[8*i +: 8] = mem_bytes[8'(mem_addr[7:0] + 8'(i))];
        mem_ack   = 1'b1;
        mem_rdata = word;
        wcnt      = 0;
        for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{mem_be[i]}};
        if (exp_txn.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_txn: actual addr=%0h be=%b, required no transaction",
                   mem_addr, mem_be);
        end else begin
          e = exp_txn.pop_front();
          checkOutput("txn", 72'({mem_we, mem_addr, mem_be, mem_wdata & lane_mask}),
                      72'({e.we, e.addr, e.be, e.wdata}));
        end
        if (mem_we) begin
          for (int i = 0; i < 4; i++)
            if (mem_be[i]) mem_bytes[8'(mem_addr[7:0] + 8'(i))] = mem_wdata[8*i +: 8];
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        wcnt++;
      end
      prev_req = mem_req;
      prev_ack = mem_ack;
      prev_bus = {mem_we, mem_addr, mem_be, mem_wdata};
    end
  end

  // Present a request and hold it until the unit accepts it; returns the accept edge number
  task automatic acceptReq(input logic we, input logic [1:0] typ, input logic u,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int acc_cyc);
    logic seen;
    @(negedge clk);
    #1;
    req_we    = we;
    req_type  = typ;
    req_u     = u;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    acc_cyc   = -1;
    for (int k = 0; k < 50; k++) begin
      seen = req_ready;
      @(posedge clk);
      #1;
      if (seen) begin
        acc_cyc = cyc;
        break;
      end
    end
    req_valid = 1'b0;
    if (acc_cyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: actual req_ready never 1, required accept");
    end
  endtask

  // Build the expected transactions byte by byte, issue the request and wait for its response
  task automatic applyStimulus(input vec_t v);
    int          n;
    int          lane;
    int          acc;
    logic [31:0] first_wa;
    logic [31:0] a;
    txn_t        t0;
    txn_t        t1;
    rsp_t        r;
    n = (v.typ == 2'b00) ? 1 : (v.typ == 2'b01) ? 2 : 4;
    first_wa = v.addr & 32'hFFFF_FFFC;
    t0 = '{v.we, first_wa, 4'b0000, 32'h0};
    t1 = '{v.we, first_wa + 32'd4, 4'b0000, 32'h0};
    for (int i = 0; i < n; i++) begin
      a = v.addr + 32'(i);
      lane = int'(a[1:0]);
      if ((a & 32'hFFFF_FFFC) == first_wa) begin
        t0.be[lane] = 1'b1;
        t0.wdata[8*lane +: 8] = v.wdata[8*i +: 8];
      end else begin
        t1.be[lane] = 1'b1;
        t1.wdata[8*lane +: 8] = v.wdata[8*i +: 8];
      end
    end
    exp_txn.push_back(t0);
    if (t1.be != 4'b0000) exp_txn.push_back(t1);
    wait_cfg = v.waits;
    acceptReq(v.we, v.typ, v.u, v.addr, v.wdata, acc);
    if (acc < 0) begin
      exp_txn.delete();
      return;
    end
    r = '{v.exp_rdata, v.exp_lat, acc, v.name};
    exp_rsp.push_back(r);
    for (int k = 0; k < 200; k++) begin
      if (exp_rsp.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_rsp.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_rsp_timeout: actual no rsp_valid, required response", v.name);
      exp_rsp.delete();
    end
    checkOutput({v.name, "_txn_left"}, 72'(exp_txn.size()), 72'(0));
    exp_txn.delete();
  endtask

  initial begin
    int acc;
    int found;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_type  = 2'b00;
    req_u     = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 256; i++) mem_bytes[i] = 8'h00;
    setWord(8'h00, 32'hAABBCCDD);
    setWord(8'h04, 32'h44332211);
    setWord(8'h08, 32'h88776655);
    setWord(8'h10, 32'h80123456);
    setWord(8'h20, 32'hCAFEF00D);
    setWord(8'h30, 32'h80017FFF);
    setWord(8'hFC, 32'h11223344);

    //            we    type   u     addr          wdata         w  rdata         lat name
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h00000013, 32'h00000000, 0, 32'hFFFFFF80, 2, "ldb_s_13"});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h00000013, 32'h00000000, 0, 32'h00000080, 2, "ldb_u_13"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h00000006, 32'h00000000, 0, 32'h66554433, 3, "ldw_split_06"});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h00000011, 32'h00000000, 0, 32'h00000034, 2, "ldb_s_11"});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h00000032, 32'h00000000, 0, 32'hFFFF8001, 2, "ldh_s_32"});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h00000032, 32'h00000000, 0, 32'h00008001, 2, "ldh_u_32"});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h00000030, 32'h00000000, 0, 32'h00007FFF, 2, "ldh_s_30"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h00000020, 32'h00000000, 3, 32'hCAFEF00D, 5, "ldw_wait3"});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h00000000, 0, 32'hFFFFDD11, 3, "ldh_wrap"});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF, 0, 32'h00000000, 2, "stw_10"});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000000F, 32'h0000ABCD, 0, 32'h00000000, 3, "sth_split_0f"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000000D, 32'h00000000, 0, 32'hABCD0000, 3, "ldw_0d"});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h00000022, 32'hFFFFFFEE, 1, 32'h00000000, 3, "stb_22"});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h00000020, 32'h00000000, 0, 32'hCAEEF00D, 2, "ld_t3_20"});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h00000005, 32'h12345678, 0, 32'h00000000, 3, "stw_split_05"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h00000004, 32'h00000000, 0, 32'h34567811, 2, "ldw_04"});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h00000007, 32'h00000000, 2, 32'h00001234, 7, "ldh_u_07_w2"});

    #1;
    checkOutput("reset_ready", 72'(req_ready), 72'(1));
    checkOutput("reset_outputs",
                72'({rsp_valid, mem_req, mem_we, mem_be, mem_addr[3:0], mem_wdata[3:0]}), 72'(0));
    checkOutput("reset_rdata", 72'(rsp_rdata), 72'(0));
    checkOutput("reset_addr_wdata", 72'({mem_addr, mem_wdata}), 72'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Reset asserted while the second half of a split store is waiting on its ack
    $display("[TB] reset abort during split store");
    wait_cfg = 4;
    exp_txn.push_back('{1'b1, 32'h0000000C, 4'b1100, 32'h99990000});
    acceptReq(1'b1, 2'b10, 1'b0, 32'h0000000E, 32'h99999999, acc);
    found = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (mem_req && mem_addr == 32'h00000010) begin
        found = 1;
        break;
      end
    end
    checkOutput("abort_reached_acc1", 72'(found), 72'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_mem_req", 72'(mem_req), 72'(0));
    checkOutput("abort_rsp_valid", 72'(rsp_valid), 72'(0));
    checkOutput("abort_ready", 72'(req_ready), 72'(1));
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("abort_idle_ready", 72'(req_ready), 72'(1));
    checkOutput("abort_idle_req", 72'(mem_req), 72'(0));
    checkOutput("abort_txn_left", 72'(exp_txn.size()), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
